multi_sel_chk: RTL and testbench
================================

Name: multi_sel_chk

Overview:
- Receive-side checker and decoder for the 4-word constant-multiple stream produced by the team's multiplier block.
- Stream format, one word per cycle: w0=d, w1=3d, w2=7d, w3=8d. The frame marker is high together with w0.
- The block locks onto the frame, recovers d, and verifies w1..w3 against d with shift-add arithmetic.
- It reports, per frame, the recovered value with a valid pulse and a mismatch flag, plus sync errors and a saturating error count. It sits directly after the multiplier in the datapath.

Parameters:
- CNT_W, 8, width of the saturating error counter err_cnt.

Ports:
- clk  input  1  system clock, all state updates on the rising edge
- rst  input  1  asynchronous active-low reset
- din  input  11  stream word, sampled every rising edge
- frame_start  input  1  frame marker, high in the cycle din carries w0 (driven by the multiplier's input_grant)
- d_out  output  8  recovered d of the last completed frame
- d_valid  output  1  one-cycle pulse when d_out/frame_err are updated
- frame_err  output  1  value mismatch in the completed frame, qualified by d_valid
- sync_err  output  1  one-cycle pulse on framing violation
- locked  output  1  high while state is LOCK
- err_cnt  output  CNT_W  saturating count of frame_err and sync_err events

Behaviour:
- Reset (rst=0, asynchronous): d_out=0, d_valid=0, frame_err=0, sync_err=0, locked=0, err_cnt=0, state=HUNT, slot=0, d_reg=0, mis=0.
- Clocking: all outputs are registered and all inputs are sampled at the rising edge.
- FSM states: HUNT, LOCK.
- HUNT:
  - Ignore din until frame_start=1.
  - On frame_start=1: capture d_reg=din[7:0]; mis=(din[10:8]!=0); slot<=1; go to LOCK.
- LOCK:
  - slot=1, frame_start=0: mis|=(din != d_reg + {d_reg,1'b0}).
  - slot=2, frame_start=0: mis|=(din != d_reg + {d_reg,1'b0} + {d_reg,2'b0}).
  - slot=3, frame_start=0: final = mis | (din != {d_reg,3'b0}).
    - Register d_out=d_reg, frame_err=final, and pulse d_valid=1 for one cycle.
    - slot<=0.
- LOCK, slot=0 (next frame expected):
  - frame_start=1: treat as a new frame (capture as in HUNT), slot<=1, stay in LOCK.
  - frame_start=0: pulse sync_err, go to HUNT, no d_valid.
- LOCK, frame_start=1 at slot 1..3 (early marker):
  - Abort the current frame with no d_valid for it, and pulse sync_err.
  - Capture din as the new w0, slot<=1, stay in LOCK.
- Latency: d_valid goes high in the cycle after the edge that samples w3, i.e. 4 cycles after the edge that sampled w0. Back-to-back frames give one d_valid every 4 cycles.
- Arithmetic: expected values are computed 11 bits wide with no overflow (max 8*255=2040). Compare din exactly, all 11 bits.
- err_cnt:
  - Increments by 1 on each cycle where (d_valid & frame_err) or sync_err is being asserted.
  - If both occur in the same cycle, it increments by 2. This cannot happen with the legal state flow, but saturation must still hold.
  - Saturates at 2^CNT_W-1 and never wraps.
- locked = (state==LOCK), registered.
- d_out/frame_err hold their value between d_valid pulses.
- Reset mid-frame: all state clears immediately, any partial frame is discarded, and there is no d_valid.

Decomposition:
- Shared package: state encoding (HUNT, LOCK), slot width constant SLOT_W=2, word width constants DW=8 and WW=11.
- Sub-module multi_sel_exp (combinational):
  - Inputs: d_reg, slot.
  - Output: 11-bit expected word for slots 0..3 (d, 3d, 7d, 8d), built only from shifts and adds.

Test Plan:
- Reset, then frames d=0x55 (0x055,0x0FF,0x253,0x2A8) and d=0xFF (0x0FF,0x2FD,0x6F9,0x7F8) back-to-back -> two d_valid pulses 4 cycles apart, d_out=0x55 then 0xFF, frame_err=0, locked=1, err_cnt=0.
- Frame d=0x55 with w2 corrupted to 0x254 -> d_valid with d_out=0x55, frame_err=1, err_cnt=1, stays locked.
- w0=0x155 with frame_start=1 and the remaining words consistent with d=0x55 -> frame_err=1 (upper bits nonzero).
- Locked stream, frame_start withheld at the expected slot 0 -> sync_err pulse, locked=0, no d_valid. The next frame_start relocks, and the following frame gives d_valid with frame_err=0.
- frame_start reasserted at slot 2 -> sync_err pulse, first frame produces no d_valid, new frame completes normally 4 cycles after the new marker.
- CNT_W=2, five corrupted frames -> err_cnt reads 1,2,3,3,3. Assert rst mid-frame -> all outputs 0 immediately, no d_valid afterwards until a new frame completes.

Source files
------------

// File: rtl/multi_sel_chk_pkg.sv
// Shared types and widths for the constant-multiple stream checker.
package multi_sel_chk_pkg;

  localparam int SLOT_W = 2;   // word position inside a 4-word frame
  localparam int DW     = 8;   // recovered data width
  localparam int WW     = 11;  // stream word width (holds up to 8*255)

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

endpackage

// File: rtl/multi_sel_exp.sv
// Expected stream word for a frame slot, built from shifts and adds of d.
module multi_sel_exp
  import multi_sel_chk_pkg::*;
(
  input  logic [DW-1:0]     d_reg,
  input  logic [SLOT_W-1:0] slot,
  output logic [WW-1:0]     exp_word
);

  logic [WW-1:0] d1;
  logic [WW-1:0] d2;
  logic [WW-1:0] d4;
  logic [WW-1:0] d8;

  assign d1 = {3'b000, d_reg};
  assign d2 = {2'b00, d_reg, 1'b0};
  assign d4 = {1'b0, d_reg, 2'b00};
  assign d8 = {d_reg, 3'b000};

  // Select d, 3d, 7d or 8d by slot; 11 bits never overflow for 8-bit d.
  always_comb begin
    exp_word = d1;
    case (slot)
      2'd0:    exp_word = d1;
      2'd1:    exp_word = d1 + d2;
      2'd2:    exp_word = d1 + d2 + d4;
      default: exp_word = d8;
    endcase
  end

endmodule

// File: rtl/multi_sel_chk.sv
// Frame-locking checker/decoder for the w0=d, 3d, 7d, 8d multiplier stream.
module multi_sel_chk
  import multi_sel_chk_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WW-1:0]    din,
  input  logic             frame_start,
  output logic [DW-1:0]    d_out,
  output logic             d_valid,
  output logic             frame_err,
  output logic             sync_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt
);

  state_t              state, state_n;
  logic [SLOT_W-1:0]   slot, slot_n;
  logic [DW-1:0]       d_reg, d_reg_n;
  logic                mis, mis_n;
  logic [DW-1:0]       d_out_n;
  logic                d_valid_n;
  logic                frame_err_n;
  logic                sync_err_n;
  logic [1:0]          err_inc;
  logic [WW-1:0]       exp_word;
  logic                word_mis;

  // Counter add that clamps at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [1:0]       inc);
    logic [CNT_W+1:0] sum;
    sum = {2'b00, cnt} + {{CNT_W{1'b0}}, inc};
    if (sum > {2'b00, {CNT_W{1'b1}}})
      return {CNT_W{1'b1}};
    return sum[CNT_W-1:0];
  endfunction

  multi_sel_exp u_exp (
    .d_reg    (d_reg),
    .slot     (slot),
    .exp_word (exp_word)
  );

  assign word_mis = (din != exp_word);

  // Next-state and next-output decode for frame tracking.
  always_comb begin
    state_n     = state;
    slot_n      = slot;
    d_reg_n     = d_reg;
    mis_n       = mis;
    d_out_n     = d_out;
    frame_err_n = frame_err;
    d_valid_n   = 1'b0;
    sync_err_n  = 1'b0;
    case (state)
      HUNT: begin
        if (frame_start) begin
          d_reg_n = din[DW-1:0];
          mis_n   = (din[WW-1:DW] != '0);
          slot_n  = 2'd1;
          state_n = LOCK;
        end
      end
      default: begin
        if (frame_start) begin
          // A marker anywhere but slot 0 aborts the frame in progress.
          sync_err_n = (slot != 2'd0);
          d_reg_n    = din[DW-1:0];
          mis_n      = (din[WW-1:DW] != '0);
          slot_n     = 2'd1;
        end else if (slot == 2'd0) begin
          sync_err_n = 1'b1;
          state_n    = HUNT;
        end else if (slot == 2'd3) begin
          d_out_n     = d_reg;
          frame_err_n = mis | word_mis;
          d_valid_n   = 1'b1;
          slot_n      = 2'd0;
        end else begin
          mis_n  = mis | word_mis;
          slot_n = slot + 2'd1;
        end
      end
    endcase
    err_inc = {1'b0, d_valid_n & frame_err_n} + {1'b0, sync_err_n};
  end

  // State, datapath and output registers; counter tracks the outputs it registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= HUNT;
      slot      <= '0;
      d_reg     <= '0;
      mis       <= 1'b0;
      d_out     <= '0;
      d_valid   <= 1'b0;
      frame_err <= 1'b0;
      sync_err  <= 1'b0;
      locked    <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      slot      <= slot_n;
      d_reg     <= d_reg_n;
      mis       <= mis_n;
      d_out     <= d_out_n;
      d_valid   <= d_valid_n;
      frame_err <= frame_err_n;
      sync_err  <= sync_err_n;
      locked    <= (state_n == LOCK);
      err_cnt   <= sat_add(err_cnt, err_inc);
    end
  end

endmodule

// File: tb/tb_multi_sel_chk.sv
// Self-checking bench: directed vector table, random frames against a queue model,
// counter saturation with CNT_W=2 and reset mid-frame.
module tb_multi_sel_chk;

  logic        clk;
  logic        rst;
  logic [10:0] din;
  logic        frame_start;
  logic [7:0]  d_out, d_out2;
  logic        d_valid, d_valid2;
  logic        frame_err, frame_err2;
  logic        sync_err, sync_err2;
  logic        locked, locked2;
  logic [7:0]  err_cnt;
  logic [1:0]  err_cnt2;

  int checks = 0;
  int errors = 0;

  multi_sel_chk #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .frame_start(frame_start),
    .d_out(d_out), .d_valid(d_valid), .frame_err(frame_err),
    .sync_err(sync_err), .locked(locked), .err_cnt(err_cnt)
  );

  multi_sel_chk #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .din(din), .frame_start(frame_start),
    .d_out(d_out2), .d_valid(d_valid2), .frame_err(frame_err2),
    .sync_err(sync_err2), .locked(locked2), .err_cnt(err_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  // Reference model: words since the last marker kept in a queue.
  bit          m_lock;
  int unsigned m_words[$];
  int unsigned m_dout;
  bit          m_ferr, m_dv, m_serr;
  int          m_ev;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_lock = 0; m_words.delete(); m_dout = 0; m_ferr = 0;
    m_dv = 0; m_serr = 0; m_ev = 0;
  endfunction

  function automatic void model_step(input int unsigned w, input bit fs);
    int unsigned d;
    m_dv = 0; m_serr = 0;
    if (fs) begin
      if (m_lock && m_words.size() != 0) m_serr = 1;
      m_words.delete();
      m_words.push_back(w);
      m_lock = 1;
    end else if (m_lock) begin
      if (m_words.size() == 0) begin
        m_serr = 1;
        m_lock = 0;
      end else begin
        m_words.push_back(w);
        if (m_words.size() == 4) begin
          d = m_words[0] % 256;
          m_ferr = (m_words[0] != d) || (m_words[1] != 3*d) ||
                   (m_words[2] != 7*d) || (m_words[3] != 8*d);
          m_dout = d;
          m_dv = 1;
          m_words.delete();
        end
      end
    end
    if (m_dv && m_ferr) m_ev++;
    if (m_serr) m_ev++;
  endfunction

  task automatic check_model();
    chk("d_valid",   d_valid,   m_dv);
    chk("d_out",     d_out,     m_dout);
    chk("frame_err", frame_err, m_ferr);
    chk("sync_err",  sync_err,  m_serr);
    chk("locked",    locked,    m_lock);
    chk("err_cnt8",  err_cnt,   (m_ev > 255) ? 255 : m_ev);
    chk("err_cnt2",  err_cnt2,  (m_ev > 3) ? 3 : m_ev);
    chk("d_valid2",  d_valid2,  m_dv);
    chk("d_out2",    d_out2,    m_dout);
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cycle(input logic [10:0] w, input bit fs);
    din = w;
    frame_start = fs;
    @(posedge clk);
    model_step(w, fs);
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  typedef struct {
    logic [10:0] din;
    bit          fs;
    bit          dv;
    logic [7:0]  dout;
    bit          ferr;
    bit          serr;
    bit          lk;
    int          cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [10:0] w, input bit fs, input bit dv,
                              input logic [7:0] dout, input bit ferr, input bit serr,
                              input bit lk, input int cnt);
    vec_t v;
    v.din = w; v.fs = fs; v.dv = dv; v.dout = dout;
    v.ferr = ferr; v.serr = serr; v.lk = lk; v.cnt = cnt;
    tbl.push_back(v);
  endfunction

  int exp5[5] = '{1, 2, 3, 3, 3};

  initial begin
    rst = 1'b0;
    din = '0;
    frame_start = 1'b0;
    model_reset();
    #12;
    chk("rst_d_out", d_out, 0);
    chk("rst_d_valid", d_valid, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err_cnt", err_cnt, 0);
    @(negedge clk);
    rst = 1'b1;

    // din fs | dv dout ferr serr lk cnt
    add(11'h055,1, 0,8'h00,0,0,1,0);
    add(11'h0FF,0, 0,8'h00,0,0,1,0);
    add(11'h253,0, 0,8'h00,0,0,1,0);
    add(11'h2A8,0, 1,8'h55,0,0,1,0);
    add(11'h0FF,1, 0,8'h55,0,0,1,0);
    add(11'h2FD,0, 0,8'h55,0,0,1,0);
    add(11'h6F9,0, 0,8'h55,0,0,1,0);
    add(11'h7F8,0, 1,8'hFF,0,0,1,0);
    // w2 corrupted
    add(11'h055,1, 0,8'hFF,0,0,1,0);
    add(11'h0FF,0, 0,8'hFF,0,0,1,0);
    add(11'h254,0, 0,8'hFF,0,0,1,0);
    add(11'h2A8,0, 1,8'h55,1,0,1,1);
    // upper bits set in w0
    add(11'h155,1, 0,8'h55,1,0,1,1);
    add(11'h0FF,0, 0,8'h55,1,0,1,1);
    add(11'h253,0, 0,8'h55,1,0,1,1);
    add(11'h2A8,0, 1,8'h55,1,0,1,2);
    // marker withheld at slot 0
    add(11'h055,0, 0,8'h55,1,1,0,3);
    add(11'h000,0, 0,8'h55,1,0,0,3);
    add(11'h0FF,1, 0,8'h55,1,0,1,3);
    add(11'h2FD,0, 0,8'h55,1,0,1,3);
    add(11'h6F9,0, 0,8'h55,1,0,1,3);
    add(11'h7F8,0, 1,8'hFF,0,0,1,3);
    // marker reasserted at slot 2
    add(11'h055,1, 0,8'hFF,0,0,1,3);
    add(11'h0FF,0, 0,8'hFF,0,0,1,3);
    add(11'h0FF,1, 0,8'hFF,0,1,1,4);
    add(11'h2FD,0, 0,8'hFF,0,0,1,4);
    add(11'h6F9,0, 0,8'hFF,0,0,1,4);
    add(11'h7F8,0, 1,8'hFF,0,0,1,4);

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].din, tbl[i].fs);
      chk("tv_d_valid",   d_valid,   tbl[i].dv);
      chk("tv_d_out",     d_out,     tbl[i].dout);
      chk("tv_frame_err", frame_err, tbl[i].ferr);
      chk("tv_sync_err",  sync_err,  tbl[i].serr);
      chk("tv_locked",    locked,    tbl[i].lk);
      chk("tv_err_cnt",   err_cnt,   tbl[i].cnt);
    end

    // Random frames with occasional corruption and marker glitches.
    for (int f = 0; f < 80; f++) begin
      int unsigned d;
      int unsigned w;
      bit fs;
      d = $urandom_range(0, 255);
      for (int k = 0; k < 4; k++) begin
        w = (k == 0) ? d : (k == 1) ? 3*d : (k == 2) ? 7*d : 8*d;
        if ($urandom_range(0, 15) == 0) w = w ^ (1 << $urandom_range(0, 10));
        fs = (k == 0);
        if ($urandom_range(0, 19) == 0) fs = !fs;
        cycle(w[10:0], fs);
      end
    end

    // Saturation of the 2-bit counter over five bad frames.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cycle(11'h010, 1'b1);
      cycle(11'h030, 1'b0);
      cycle(11'h070, 1'b0);
      cycle(11'h081, 1'b0);
      chk("sat_d_valid", d_valid2, 1);
      chk("sat_err_cnt2", err_cnt2, exp5[i]);
    end

    // Reset mid-frame clears everything without waiting for a clock.
    cycle(11'h020, 1'b1);
    cycle(11'h060, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_d_out", d_out, 0);
    chk("mid_frame_err", frame_err, 0);
    chk("mid_locked", locked, 0);
    chk("mid_err_cnt", err_cnt, 0);
    chk("mid_err_cnt2", err_cnt2, 0);
    chk("mid_d_valid", d_valid, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(11'h0E0, 1'b0);
    cycle(11'h100, 1'b0);
    chk("post_rst_no_valid", d_valid, 0);
    cycle(11'h021, 1'b1);
    cycle(11'h063, 1'b0);
    cycle(11'h0E7, 1'b0);
    cycle(11'h108, 1'b0);
    chk("post_rst_valid", d_valid, 1);
    chk("post_rst_d_out", d_out, 8'h21);
    chk("post_rst_ferr", frame_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
